// File: rtl/ibex_pkg.sv
// Shared types for the fetch-side alignment buffer.
package ibex_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/ibex_fetch_align_buffer.sv
// Fetch word buffer and halfword realigner feeding the compressed decoder;
// emits one (possibly straddling) instruction per handshake and tracks its PC.
module ibex_fetch_align_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned Depth     = 3,
  parameter logic [31:0] ResetAddr = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  if (Depth < 2) begin : g_depth_check
    $error("ibex_fetch_align_buffer: Depth must be at least 2");
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] res;
    if (ptr == PtrW'(Depth - 1)) begin
      res = PtrW'(0);
    end else begin
      res = ptr + PtrW'(1);
    end
    return res;
  endfunction

  fetch_entry_t    mem_r [Depth];
  logic [PtrW-1:0] rd_ptr_r, wr_ptr_r, nxt_ptr_s;
  logic [CntW-1:0] count_r;
  logic [31:0]     addr_r;

  fetch_entry_t    head_s, next_s;
  logic [15:0]     lo_s, next_lo_s;
  logic            has1_s, has2_s;
  logic            valid_s, err_s, compressed_s, fire_s;
  logic [31:0]     rdata_s, addr_nxt_s;
  logic            push_s, pop_s;
  logic            unused_addr_lsb_s;

  assign unused_addr_lsb_s = clear_addr_i[0];
  assign nxt_ptr_s  = ptr_inc(rd_ptr_r);
  assign in_ready_o = (count_r != CntW'(Depth));
  assign push_s     = in_valid_i & in_ready_o & ~clear_i;

  // Instruction formation from the head/next entries and the current PC alignment.
  always_comb begin
    head_s    = mem_r[rd_ptr_r];
    next_s    = mem_r[nxt_ptr_s];
    lo_s      = head_s.rdata[31:16];
    has1_s    = (count_r >= CntW'(1));
    has2_s    = (count_r >= CntW'(2));
    next_lo_s = has2_s ? next_s.rdata[15:0] : 16'h0000;
    valid_s   = 1'b0;
    rdata_s   = 32'h0000_0000;
    err_s     = 1'b0;
    if (!addr_r[1]) begin
      valid_s = has1_s;
      rdata_s = head_s.rdata;
      err_s   = head_s.err;
    end else if (head_s.err) begin
      valid_s = has1_s;
      rdata_s = {next_lo_s, lo_s};
      err_s   = 1'b1;
    end else if (lo_s[1:0] != 2'b11) begin
      valid_s = has1_s;
      rdata_s = {next_lo_s, lo_s};
      err_s   = 1'b0;
    end else begin
      // Uncompressed straddling instruction needs the upper half from the next word.
      valid_s = has2_s;
      rdata_s = {next_s.rdata[15:0], lo_s};
      err_s   = next_s.err;
    end
    valid_s = valid_s & ~clear_i;
  end

  assign out_valid_o = valid_s;
  assign out_rdata_o = rdata_s;
  assign out_err_o   = err_s;
  assign out_addr_o  = addr_r;

  // Consume decision: whether the head entry retires and how far the PC advances.
  always_comb begin
    fire_s       = out_valid_o & out_ready_i;
    compressed_s = (out_rdata_o[1:0] != 2'b11);
    pop_s        = 1'b0;
    addr_nxt_s   = addr_r;
    if (fire_s) begin
      if (err_s) begin
        pop_s      = 1'b1;
        addr_nxt_s = {addr_r[31:2] + 30'd1, 2'b00};
      end else if (!addr_r[1]) begin
        pop_s      = ~compressed_s;
        addr_nxt_s = addr_r + (compressed_s ? 32'd2 : 32'd4);
      end else begin
        pop_s      = 1'b1;
        addr_nxt_s = addr_r + (compressed_s ? 32'd2 : 32'd4);
      end
    end else begin
      pop_s      = 1'b0;
      addr_nxt_s = addr_r;
    end
  end

  // Entry storage; a flushed push is simply never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_r[i] <= '{rdata: 32'h0000_0000, err: 1'b0};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= '{rdata: in_rdata_i, err: in_err_i};
    end
  end

  // Pointers, occupancy and PC; a redirect overrides any same-cycle push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_r <= PtrW'(0);
      wr_ptr_r <= PtrW'(0);
      count_r  <= CntW'(0);
      addr_r   <= {ResetAddr[31:1], 1'b0};
    end else if (clear_i) begin
      rd_ptr_r <= PtrW'(0);
      wr_ptr_r <= PtrW'(0);
      count_r  <= CntW'(0);
      addr_r   <= {clear_addr_i[31:1], 1'b0};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= nxt_ptr_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
      addr_r <= addr_nxt_s;
    end
  end

endmodule
